alu_mc_rv: RTL and testbench

//   Multi-cycle, parametrised integer execute unit for the RV32I/M core.

---
 rtl/alu_mc_rv.sv | 160 ++++++++++++++++
 tb/tb_alu_mc_rv.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc_rv.sv
// rtl/alu_mc_rv.sv - RV32I/M execute unit: single-cycle base ops, iterative shift-add multiply and restoring divide
module alu_mc_rv #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int SH_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     opnd_q;
    logic                neg_q;
    logic                hi_q;
    logic                out_valid_q;
    logic [XLEN-1:0]     result_q;

    logic            mext, alt;
    logic [2:0]      f3;
    logic [SH_W-1:0] shamt;
    logic            accept;

    assign mext  = op[4];
    assign alt   = op[3];
    assign f3    = op[2:0];
    assign shamt = b[SH_W-1:0];

    assign in_ready  = (state_q == S_IDLE) & (~out_valid_q | out_ready) & ~flush;
    assign accept    = in_valid & in_ready;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

    logic [XLEN-1:0] base_res;
    always_comb begin
        base_res = '0;
        case (f3)
            3'b000: base_res = alt ? a - b : a + b;
            3'b001: base_res = a << shamt;
            3'b010: base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            3'b011: base_res = {{(XLEN-1){1'b0}}, a < b};
            3'b100: base_res = a ^ b;
            3'b101: base_res = alt ? XLEN'($signed(a) >>> shamt) : a >> shamt;
            3'b110: base_res = a | b;
            default: base_res = a & b;
        endcase
    end

    // Operand signedness: MULH s*s, MULHSU s*u, DIV/REM s/s; MUL low half is sign-agnostic.
    logic            a_sgn, b_sgn;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, div_special;
    logic [XLEN-1:0] special_res;
    logic [2*XLEN-1:0] acc_init;
    logic [XLEN-1:0] opnd_init;
    logic            neg_init, hi_init;

    assign a_sgn = (f3[2] ? ~f3[0] : (f3 == 3'b001 || f3 == 3'b010)) & a[XLEN-1];
    assign b_sgn = (f3[2] ? ~f3[0] : (f3 == 3'b001)) & b[XLEN-1];
    assign a_mag = a_sgn ? -a : a;
    assign b_mag = b_sgn ? -b : b;

    assign div_zero    = (b == '0);
    assign div_ovf     = ~f3[0] & (a == MIN_VAL) & (b == '1);
    assign div_special = f3[2] & (div_zero | div_ovf);
    assign special_res = f3[1] ? (div_zero ? a : '0) : (div_zero ? '1 : MIN_VAL);

    assign acc_init  = f3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
    assign opnd_init = f3[2] ? b_mag : a_mag;
    assign neg_init  = (f3[2] & f3[1]) ? a_sgn : (a_sgn ^ b_sgn);
    assign hi_init   = f3[2] ? f3[1] : (f3 != 3'b000);

    // Multiply: acc = {partial high, remaining multiplier}; add then shift right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = ~div_diff[XLEN];
    assign div_next  = {div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], acc_q[XLEN-2:0], div_ge};

    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   mul_res, div_sel, div_res, fin_res;
    assign mul_prod = neg_q ? -mul_next : mul_next;
    assign mul_res  = hi_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
    assign div_sel  = hi_q ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    assign div_res  = neg_q ? -div_sel : div_sel;
    assign fin_res  = (state_q == S_DIV) ? div_res : mul_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            neg_q       <= 1'b0;
            hi_q        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_ready) out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (!mext) begin
                            result_q    <= base_res;
                            out_valid_q <= 1'b1;
                        end else if (div_special) begin
                            result_q    <= special_res;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= f3[2] ? S_DIV : S_MUL;
                            cnt_q   <= '0;
                            acc_q   <= acc_init;
                            opnd_q  <= opnd_init;
                            neg_q   <= neg_init;
                            hi_q    <= hi_init;
                        end
                    end
                end
                default: begin
                    acc_q <= (state_q == S_DIV) ? div_next : mul_next;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        result_q    <= fin_res;
                        out_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc_rv.sv
// tb/tb_alu_mc_rv.sv - self-checking bench for alu_mc_rv: vector table, corner sequences, random ops vs reference model
module tb_alu_mc_rv;
    localparam int XLEN = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  op = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;

    int n_chk = 0;
    int n_fail = 0;

    alu_mc_rv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        logic [4:0]  sh;
        logic [31:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        sh = y[4:0];
        r  = '0;
        p  = '0;
        if (!o[4]) begin
            case (o[2:0])
                3'd0: r = o[3] ? x - y : x + y;
                3'd1: r = x << sh;
                3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                3'd3: r = (x < y) ? 32'd1 : 32'd0;
                3'd4: r = x ^ y;
                3'd5: r = o[3] ? 32'($signed(x) >>> sh) : x >> sh;
                3'd6: r = x | y;
                default: r = x & y;
            endcase
        end else begin
            case (o[2:0])
                3'd0: begin p = ux * uy; r = p[31:0]; end
                3'd1: begin p = sx * sy; r = p[63:32]; end
                3'd2: begin p = sx * uy; r = p[63:32]; end
                3'd3: begin p = ux * uy; r = p[63:32]; end
                3'd4: r = (y == 0) ? 32'hFFFF_FFFF : (x == MINV && y == 32'hFFFF_FFFF) ? MINV : 32'($signed(x) / $signed(y));
                3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
                3'd6: r = (y == 0) ? x : (x == MINV && y == 32'hFFFF_FFFF) ? 32'd0 : 32'($signed(x) % $signed(y));
                default: r = (y == 0) ? x : x % y;
            endcase
        end
        return r;
    endfunction

    // Clock edges between the accept edge and the edge that raises out_valid.
    function automatic int model_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        if (!o[4]) return 0;
        if (o[2] && (y == 0 || (!o[0] && x == MINV && y == 32'hFFFF_FFFF))) return 0;
        return XLEN;
    endfunction

    task automatic start_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input string nm);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        #1 check({nm, " in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int lat, input string nm);
        int k;
        int bad;
        k = 0;
        bad = 0;
        start_op(o, x, y, nm);
        while (!out_valid && k < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
            @(posedge clk);
            #1 k++;
        end
        check({nm, " out_valid"}, {31'b0, out_valid}, 32'd1);
        check({nm, " latency"}, 32'(k), 32'(lat));
        check({nm, " result"}, result, exp);
        if (lat > 0) check({nm, " busy/in_ready while iterating"}, 32'(bad), 32'd0);
        check({nm, " busy after"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic watch_quiet(input int cycles, input string nm);
        int rises;
        rises = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1 if (out_valid) rises++;
        end
        check({nm, " no late result"}, 32'(rises), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t bb[4];
        logic [4:0]  ro;
        logic [31:0] rx, ry;

        vecs.push_back('{5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0});
        vecs.push_back('{5'b01000, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 0});
        vecs.push_back('{5'b01101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0});
        vecs.push_back('{5'b00101, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 0});
        vecs.push_back('{5'b00010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0});
        vecs.push_back('{5'b00011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0});
        vecs.push_back('{5'b01001, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 0});
        vecs.push_back('{5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32});
        vecs.push_back('{5'b10000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32});
        vecs.push_back('{5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32});
        vecs.push_back('{5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32});
        vecs.push_back('{5'b11000, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 32});
        vecs.push_back('{5'b10100, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 0});
        vecs.push_back('{5'b10110, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 0});
        vecs.push_back('{5'b10101, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 0});
        vecs.push_back('{5'b10111, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 0});
        vecs.push_back('{5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0});
        vecs.push_back('{5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0});
        vecs.push_back('{5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32});
        vecs.push_back('{5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32});
        vecs.push_back('{5'b10101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32});
        vecs.push_back('{5'b10111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32});

        bb[0] = '{5'b00000, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 0};
        bb[1] = '{5'b00110, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 0};
        bb[2] = '{5'b00111, 32'hFFFF_00FF, 32'h0F0F_0F0F, 32'h0F0F_000F, 0};
        bb[3] = '{5'b01000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0};

        // Reset state
        #12;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

        // Back-to-back base ops: one result per cycle
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            op = bb[i].op; a = bb[i].a; b = bb[i].b; in_valid = 1'b1;
            #1 check($sformatf("b2b%0d in_ready", i), {31'b0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d out_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("b2b%0d result", i), result, bb[i].exp);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 check("b2b drain out_valid", {31'b0, out_valid}, 32'd0);

        // Output stall with a pending beat
        @(negedge clk);
        out_ready = 1'b0;
        op = 5'b00000; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        @(posedge clk);
        #1 check("stall first result", result, 32'd7);
        @(negedge clk);
        op = 5'b00100; a = 32'h0000_00F0; b = 32'h0000_000F;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d out_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("stall%0d result", i), result, 32'd7);
            check($sformatf("stall%0d in_ready", i), {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 check("stall release in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("stall pending out_valid", {31'b0, out_valid}, 32'd1);
        check("stall pending result", result, 32'h0000_00FF);
        @(negedge clk);
        in_valid = 1'b0;

        // Beat presented together with flush is refused
        @(negedge clk);
        op = 5'b00000; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        #1 check("flush beat in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        check("flush beat out_valid", {31'b0, out_valid}, 32'd0);

        // Flush in cycle 10 of DIVU
        start_op(5'b10101, 32'd1000, 32'd3, "flushdiv");
        for (int i = 0; i < 8; i++) @(posedge clk);
        @(negedge clk);
        check("flushdiv busy before", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        #1;
        check("flushdiv out_valid", {31'b0, out_valid}, 32'd0);
        check("flushdiv busy", {31'b0, busy}, 32'd0);
        check("flushdiv in_ready", {31'b0, in_ready}, 32'd1);
        watch_quiet(40, "flushdiv");

        // Reset in cycle 20 of MUL
        start_op(5'b10000, 32'd12345, 32'd678, "rstmul");
        for (int i = 0; i < 18; i++) @(posedge clk);
        @(negedge clk);
        check("rstmul busy before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmul out_valid", {31'b0, out_valid}, 32'd0);
        check("rstmul busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rstmul in_ready", {31'b0, in_ready}, 32'd1);
        watch_quiet(40, "rstmul");

        // Random ops against the reference model
        for (int i = 0; i < 80; i++) begin
            ro = 5'($urandom_range(0, 31));
            rx = $urandom;
            if ($urandom_range(0, 7) == 0) rx = MINV;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: ry = 32'hFFFF_FFFF;
                2: ry = 32'($urandom_range(1, 15));
                default: ry = $urandom;
            endcase
            run_op(ro, rx, ry, model(ro, rx, ry), model_lat(ro, rx, ry), $sformatf("rnd%0d op%b", i, ro));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
